// File: rtl/gsens_tilt_filter.sv
// gsens_tilt_filter
//   Samples a signed accelerometer axis word on every data-ready interrupt and
//   averages 2^AVG_LOG2 samples per window. It converts the average to a
//   saturating sign/magnitude value and quantises it to OUT_W bits. A dead zone
//   and a stability debounce are then applied before the result is published.
//
// Ports
//   clk            system clock
//   resetN         asynchronous active-low reset
//   enable         synchronous enable; low clears window/debounce state, holds outputs
//   iDIG           signed sample, stable while iG_INT2 is high
//   iG_INT2        data-ready interrupt, asynchronous to clk
//   tilt_amount    published quantised magnitude
//   tilt_direction published sign (1 = negative)
//   tilt_valid     one-cycle pulse when the published value changes
//   window_done    one-cycle pulse per evaluated window result
module gsens_tilt_filter #(
  parameter int DATA_W     = 10,
  parameter int OUT_W      = 4,
  parameter int AVG_LOG2   = 2,
  parameter int DEADZONE   = 1,
  parameter int STABLE_CNT = 2
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              enable,
  input  logic [DATA_W-1:0] iDIG,
  input  logic              iG_INT2,
  output logic [OUT_W-1:0]  tilt_amount,
  output logic              tilt_direction,
  output logic              tilt_valid,
  output logic              window_done
);

  localparam int              ACC_W    = DATA_W + AVG_LOG2;
  localparam int              CNT_W    = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);
  localparam int              ST_W     = $clog2(STABLE_CNT + 1);
  localparam logic [ST_W-1:0] STAB_MAX = ST_W'(STABLE_CNT);
  localparam logic [OUT_W:0]  DZ       = (OUT_W + 1)'(DEADZONE);

  // ---------------------------------------------------------------------------
  // Interrupt synchroniser and rising-edge detect
  // ---------------------------------------------------------------------------
  logic r_sync1, r_sync2, r_sync3;
  logic w_edge;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= iG_INT2;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_sync3;

  // ---------------------------------------------------------------------------
  // Window accumulator
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_window_sum;
  logic signed [ACC_W-1:0] w_sample;
  logic signed [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_close;

  assign w_sample   = ACC_W'($signed(iDIG));
  assign w_acc_next = r_acc + w_sample;

  // The closing sample goes straight into window_sum while the accumulator
  // restarts from zero, so back-to-back windows lose nothing.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_window_sum <= '0;
      r_close      <= 1'b0;
    end else begin
      r_close <= 1'b0;
      if (!enable) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_edge) begin
        if (r_cnt == LAST_IDX) begin
          r_window_sum <= w_acc_next;
          r_acc        <= '0;
          r_cnt        <= '0;
          r_close      <= 1'b1;
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage E: average, saturating absolute value, quantise, dead zone
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0]  w_avg_full;
  logic signed [DATA_W-1:0] w_avg;
  logic [DATA_W-1:0]        w_mag;
  logic [OUT_W-1:0]         w_q;
  logic                     w_dir;
  logic                     w_unused;

  assign w_avg_full = r_window_sum >>> AVG_LOG2;
  assign w_avg      = w_avg_full[DATA_W-1:0];

  always_comb begin
    w_dir = w_avg[DATA_W-1];
    if (!w_dir)
      w_mag = w_avg;
    else if (w_avg == {1'b1, {(DATA_W-1){1'b0}}})
      // Negating the most-negative value would wrap; clamp to the largest magnitude.
      w_mag = {1'b0, {(DATA_W-1){1'b1}}};
    else
      w_mag = -w_avg;
    w_q = w_mag[DATA_W-2 -: OUT_W];
    if ({1'b0, w_q} < DZ) begin
      w_q   = '0;
      w_dir = 1'b0;
    end
  end

  // Bits of the averaged word that the quantiser does not look at.
  assign w_unused = ^{w_avg_full, w_mag};

  logic             r_e_valid;
  logic             r_e_dir;
  logic [OUT_W-1:0] r_e_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_e_valid <= 1'b0;
      r_e_dir   <= 1'b0;
      r_e_q     <= '0;
    end else begin
      r_e_valid <= r_close & enable;
      if (r_close) begin
        r_e_dir <= w_dir;
        r_e_q   <= w_q;
      end
    end
  end

  assign window_done = r_e_valid;

  // ---------------------------------------------------------------------------
  // Stage C: stability debounce and publish
  // ---------------------------------------------------------------------------
  logic [OUT_W:0]  r_cand;
  logic [OUT_W:0]  w_res;
  logic [ST_W-1:0] r_stab;
  logic [ST_W-1:0] w_stab_next;
  logic            w_publish;

  assign w_res = {r_e_dir, r_e_q};

  always_comb begin
    if (w_res != r_cand)
      w_stab_next = ST_W'(1);
    else if (r_stab == STAB_MAX)
      w_stab_next = r_stab;
    else
      w_stab_next = r_stab + ST_W'(1);
    w_publish = (w_stab_next == STAB_MAX) && (w_res != {tilt_direction, tilt_amount});
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cand         <= '0;
      r_stab         <= '0;
      tilt_amount    <= '0;
      tilt_direction <= 1'b0;
      tilt_valid     <= 1'b0;
    end else begin
      tilt_valid <= 1'b0;
      if (!enable) begin
        r_cand <= '0;
        r_stab <= '0;
      end else if (r_e_valid) begin
        r_cand <= w_res;
        r_stab <= w_stab_next;
        if (w_publish) begin
          {tilt_direction, tilt_amount} <= w_res;
          tilt_valid                    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gsens_tilt_filter.sv
// tb_gsens_tilt_filter
//   Drives two filter instances (default dead zone and DEADZONE=2) with the same
//   interrupt/sample stream. A behavioural model built from window sample
//   lists and a short result history predicts every output on every cycle;
//   literal checks pin the model on the hand-worked scenarios.
module tb_gsens_tilt_filter;

  localparam int NS = 4;   // samples per window (AVG_LOG2 = 2)

  logic       clk = 1'b0;
  logic       resetN;
  logic       enable;
  logic       iG_INT2;
  logic [9:0] iDIG;

  logic [3:0] amt0, amt1;
  logic       dir0, dir1, tv0, tv1, wd0, wd1;

  gsens_tilt_filter u_dut0 (
    .clk(clk), .resetN(resetN), .enable(enable), .iDIG(iDIG), .iG_INT2(iG_INT2),
    .tilt_amount(amt0), .tilt_direction(dir0), .tilt_valid(tv0), .window_done(wd0)
  );

  gsens_tilt_filter #(.DEADZONE(2)) u_dut1 (
    .clk(clk), .resetN(resetN), .enable(enable), .iDIG(iDIG), .iG_INT2(iG_INT2),
    .tilt_amount(amt1), .tilt_direction(dir1), .tilt_valid(tv1), .window_done(wd1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {int left; int val;} pend_t;
  pend_t pq[$];          // interrupts in flight: clocks left until capture
  int    win[$];         // samples of the current window
  int    dzs[2] = '{1, 2};
  int    res_w[2], res_c[2];
  int    last_res[2][2]; // two most recent window results since clear
  int    nres[2];
  int    pub[2];         // published {dir,q} as dir*16+q
  bit    m_tv[2];
  bit    m_wd, wd_pend, pub_pend;
  int    cyc = 0;
  bit    cap;
  int    cv, s;

  function automatic int win_result(input int sum, input int dz);
    int avg, mag, q, dir;
    avg = sum >>> 2;                 // floor of sum/4
    dir = (avg < 0) ? 1 : 0;
    mag = (avg < 0) ? -avg : avg;
    if (mag > 511) mag = 511;
    q = mag / 32;
    if (q < dz) begin
      q   = 0;
      dir = 0;
    end
    return dir * 16 + q;
  endfunction

  always @(posedge clk) begin
    cyc++;
    cap = 1'b0;
    foreach (pq[k]) pq[k].left--;
    if (pq.size() != 0 && pq[0].left <= 0) begin
      cap = 1'b1;
      cv  = pq[0].val;
      void'(pq.pop_front());
    end
    if (!resetN || !enable) begin
      win.delete();
      wd_pend  = 1'b0;
      pub_pend = 1'b0;
      m_wd     = 1'b0;
      for (int i = 0; i < 2; i++) begin
        nres[i] = 0;
        m_tv[i] = 1'b0;
        if (!resetN) pub[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_tv[i] = 1'b0;
        if (pub_pend) begin
          last_res[i][0] = last_res[i][1];
          last_res[i][1] = res_c[i];
          if (nres[i] < 2) nres[i]++;
          // Published once the last two window results agree and are new.
          if (nres[i] == 2 && last_res[i][0] == last_res[i][1] && last_res[i][1] != pub[i]) begin
            pub[i]  = last_res[i][1];
            m_tv[i] = 1'b1;
          end
        end
        res_c[i] = res_w[i];
      end
      pub_pend = wd_pend;
      m_wd     = wd_pend;
      wd_pend  = 1'b0;
      if (cap) begin
        win.push_back(cv);
        if (win.size() == NS) begin
          s = 0;
          foreach (win[k]) s += win[k];
          for (int i = 0; i < 2; i++) res_w[i] = win_result(s, dzs[i]);
          wd_pend = 1'b1;
          win.delete();
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare
  // ---------------------------------------------------------------------------
  int tvc[2], wdc[2], tv_cyc[2], wd_cyc[2];
  logic [6:0] act, exp_v;
  logic [4:0] pb;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      act = (i == 0) ? {amt0, dir0, tv0, wd0} : {amt1, dir1, tv1, wd1};
      pb  = 5'(pub[i]);
      exp_v = resetN ? {pb[3:0], pb[4], m_tv[i], m_wd} : 7'd0;
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL cycle_dut%0d t=%0t {amt,dir,tv,wd} actual=%h expected=%h", i, $time, act, exp_v);
      end
      if (act[1] === 1'b1) begin tvc[i]++; tv_cyc[i] = cyc; end
      if (act[0] === 1'b1) begin wdc[i]++; wd_cyc[i] = cyc; end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int drive_cyc;

  task automatic chk(input string name, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, a, e);
    end
  endtask

  task automatic send(input int v);
    logic [31:0] w;
    w = v;
    @(posedge clk); #1;
    iDIG    = w[9:0];
    iG_INT2 = 1'b1;
    pq.push_back('{left: 3, val: v});
    drive_cyc = cyc;
    repeat (3) @(posedge clk);
    #1 iG_INT2 = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 resetN = 1'b0;
    idle(3);
    chk("reset_amt0", int'(amt0), 0);
    chk("reset_tv0", int'(tv0), 0);
    @(posedge clk); #1 resetN = 1'b1;
  endtask

  task automatic windows(input int v, input int n);
    for (int k = 0; k < n * NS; k++) send(v);
    idle(4);
  endtask

  int t0, t1;

  initial begin
    resetN  = 1'b0;
    enable  = 1'b1;
    iG_INT2 = 1'b0;
    iDIG    = '0;
    idle(3);
    chk("reset_state", int'({amt0, dir0, tv0, wd0}), 0);
    @(posedge clk); #1 resetN = 1'b1;
    idle(2);

    // Two windows of 96: no change on the first, publish 3 on the second.
    windows(96, 1);
    chk("w96_first_amt", int'(amt0), 0);
    chk("w96_first_tv", tvc[0], 0);
    chk("w96_first_wd", wdc[0], 1);
    windows(96, 1);
    chk("w96_amt", int'(amt0), 3);
    chk("w96_dir", int'(dir0), 0);
    chk("w96_tvcount", tvc[0], 1);
    chk("tv_latency", tv_cyc[0] - drive_cyc, 5);
    chk("wd_latency", wd_cyc[0] - drive_cyc, 4);

    // True absolute value of a negative average.
    windows(-96, 2);
    chk("neg96_amt", int'(amt0), 3);
    chk("neg96_dir", int'(dir0), 1);
    chk("neg96_tvcount", tvc[0], 2);

    // Most-negative sample saturates.
    windows(-512, 2);
    chk("min_amt", int'(amt0), 15);
    chk("min_dir", int'(dir0), 1);

    // Dead zone: q=1 is forced to 0 only in the DEADZONE=2 instance.
    do_reset();
    t1 = tvc[1];
    windows(-40, 2);
    chk("dz2_amt", int'(amt1), 0);
    chk("dz2_dir", int'(dir1), 0);
    chk("dz2_no_tv", tvc[1] - t1, 0);
    chk("dz1_amt", int'(amt0), 1);
    chk("dz1_dir", int'(dir0), 1);

    // Alternating windows never settle; two equal ones do.
    do_reset();
    windows(96, 2);
    chk("alt_base_amt", int'(amt0), 3);
    t0 = tvc[0];
    for (int k = 0; k < 3; k++) begin
      windows(160, 1);
      windows(96, 1);
    end
    chk("alt_amt_hold", int'(amt0), 3);
    chk("alt_no_tv", tvc[0] - t0, 0);
    windows(160, 2);
    chk("alt_settle_amt", int'(amt0), 5);
    chk("alt_settle_tv", tvc[0] - t0, 1);

    // Reset in the middle of a window discards it.
    send(96);
    send(96);
    do_reset();
    windows(96, 1);
    chk("post_reset_4_amt", int'(amt0), 0);
    windows(96, 1);
    chk("post_reset_8_amt", int'(amt0), 3);

    // enable low mid-window: partial sum dropped, outputs held, edges ignored.
    t0 = tvc[0];
    send(-512);
    send(-512);
    @(posedge clk); #1 enable = 1'b0;
    send(-512);
    idle(3);
    chk("dis_hold_amt", int'(amt0), 3);
    @(posedge clk); #1 enable = 1'b1;
    windows(0, 2);
    chk("en_amt", int'(amt0), 0);
    chk("en_dir", int'(dir0), 0);
    chk("en_tvcount", tvc[0] - t0, 1);

    // Randomised traffic, compared cycle by cycle against the model.
    for (int n = 0; n < 60; n++) begin
      int v, r;
      v = int'($urandom_range(0, 1023)) - 512;
      r = int'($urandom_range(0, 19));
      if (r == 0) do_reset();
      for (int k = 0; k < NS; k++) begin
        if ($urandom_range(0, 24) == 0) begin
          @(posedge clk); #1 enable = ~enable;
        end
        if ($urandom_range(0, 3) == 0) send(int'($urandom_range(0, 1023)) - 512);
        else send(v);
      end
    end
    @(posedge clk); #1 enable = 1'b1;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gsens_tilt_filter.md
Name: gsens_tilt_filter

Overview:
Parametrised, sequential successor to the tilt parser. It samples the accelerometer axis word on each data-ready interrupt and averages 2^AVG_LOG2 samples. It converts the average to sign-magnitude with a true absolute value and quantises it to OUT_W bits, then applies a dead zone and a stability debounce before publishing tilt_amount / tilt_direction. It sits between the G-sensor SPI front end and game/CPU logic.

Parameters:
DATA_W, 10, width of signed two's-complement sample iDIG.
OUT_W, 4, width of tilt_amount; taken from magnitude bits [DATA_W-2 -: OUT_W].
AVG_LOG2, 2, log2 of samples per averaging window (0 = no averaging).
DEADZONE, 1, quantised amounts below this value are forced to 0, direction 0.
STABLE_CNT, 2, consecutive identical window results required before the output changes (>=1).

Ports:
clk  in  1  system clock.
resetN  in  1  asynchronous active-low reset.
enable  in  1  synchronous; 0 clears window accumulator and counters and holds outputs.
iDIG  in  DATA_W  signed sample; stable while iG_INT2 high.
iG_INT2  in  1  data-ready interrupt, asynchronous to clk.
tilt_amount  out  OUT_W  published quantised magnitude.
tilt_direction  out  1  published sign (1 = negative).
tilt_valid  out  1  one-cycle pulse when a published value changes.
window_done  out  1  one-cycle pulse each time a window result is evaluated.

Behaviour:
- Reset (resetN=0, async): tilt_amount=0, tilt_direction=0, tilt_valid=0, window_done=0. Sync flops, accumulator, sample counter, candidate register and stability counter all cleared.
- Interrupt path: 2-flop synchroniser plus delay flop. Edge = sync2 & ~sync3. On the edge cycle iDIG is captured (sign-extended to DATA_W+AVG_LOG2) and added to the accumulator. Edges closer than 2 cycles are not required to be distinguished.
- Window: the counter increments per edge. On the edge that completes 2^AVG_LOG2 samples:
  - accumulator+sample is copied to window_sum;
  - the accumulator and counter clear in the same cycle, so the next edge starts a new window with no lost sample.
- Stage E (cycle after window close):
  - avg = window_sum >>> AVG_LOG2 (arithmetic);
  - dir = avg sign;
  - mag = |avg|, saturating: the most-negative value maps to 2^(DATA_W-1)-1;
  - q = mag[DATA_W-2 -: OUT_W];
  - if q < DEADZONE then q=0, dir=0.
  - window_done pulses.
- Stage C (next cycle):
  - If {dir,q} equals the candidate, stab_cnt increments, saturating at STABLE_CNT. Otherwise candidate={dir,q} and stab_cnt=1.
  - If stab_cnt reaches STABLE_CNT in this cycle and the candidate differs from the published value, the outputs update on the following clock edge and tilt_valid pulses for 1 cycle.
  - An identical result produces no pulse.
- Latency: iG_INT2 rise to final-sample capture = 3 clk. Capture to window_done = 1 clk. Capture to tilt_valid = 2 clk.
- Pipeline: E and C are fully pipelined. A new window may close while C runs, with no stall or drop.
- enable=0:
  - accumulator, counter, candidate and stab_cnt clear;
  - published outputs hold;
  - edges are ignored;
  - in-flight E/C results are discarded (no window_done, no tilt_valid).
- Reset mid-window discards the partial window. The first full window after release is counted from sample 1.

Test Plan:
- Defaults, 8 interrupts with iDIG=96 -> first window_done gives no output change. Second window gives tilt_amount=3, tilt_direction=0, tilt_valid pulse 2 clk after the 8th capture.
- 8 interrupts with iDIG=-96 (10'h3A0) -> tilt_amount=3, tilt_direction=1 (true abs; must not yield 2).
- 8 interrupts with iDIG=-512 (10'h200) -> saturated magnitude 511, tilt_amount=15, tilt_direction=1.
- DEADZONE=2, 8 samples of -40 -> q=1 forced to 0: tilt_amount=0, tilt_direction=0, no tilt_valid from the reset state.
- After publishing 3, windows alternating avg 96/160 (q=3/5) for 6 windows -> tilt_amount stays 3 and tilt_valid never asserts. Two consecutive 160 windows -> tilt_amount=5 with one pulse.
- Assert resetN low after 2 of 4 samples, release, then apply 8 samples of 96 -> outputs 0 during reset; tilt_amount=3 only after the 8th post-reset sample. Toggle enable=0 mid-window -> the partial sum is discarded and outputs hold.
